// File: rtl/bus_master_port_if.sv
// Request/response handshake and bus control signals of the peripheral-bus initiator.
// The shared BUS_DATA line stays a plain inout on the master so tristate resolution remains at module level.
`timescale 1ns/1ps
interface bus_master_port_if;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WE;
  logic [7:0] REQ_ADDR;
  logic [7:0] REQ_WDATA;
  logic       RSP_VALID;
  logic       RSP_WE;
  logic [7:0] RSP_RDATA;
  logic       BUSY;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    output REQ_READY, RSP_VALID, RSP_WE, RSP_RDATA, BUSY, BUS_ADDR, BUS_WE
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA,
    input  REQ_READY, RSP_VALID, RSP_WE, RSP_RDATA, BUSY, BUS_ADDR, BUS_WE
  );
endinterface

// File: rtl/bus_master_port.sv
// Initiator of the shared 8-bit peripheral bus: accepts one request at a time, runs the
// write or latency-timed read cycle, then idles the bus for a turnaround before the next request.
`timescale 1ns/1ps
module bus_master_port #(
  parameter int         READ_LATENCY = 2,
  parameter int         WRITE_CYCLES = 1,
  parameter int         TURNAROUND   = 1,
  parameter logic [7:0] IDLE_ADDR    = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  bus_master_port_if.master bus_if,
  inout  wire  [7:0]        BUS_DATA
);

  localparam int MAX_P = (READ_LATENCY > WRITE_CYCLES)
                       ? ((READ_LATENCY > TURNAROUND) ? READ_LATENCY : TURNAROUND)
                       : ((WRITE_CYCLES > TURNAROUND) ? WRITE_CYCLES : TURNAROUND);
  localparam int CNT_W = $clog2(MAX_P + 2);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(TURNAROUND - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic       we_r;
  logic       we_nxt_s;
  logic [7:0] addr_r;
  logic [7:0] addr_nxt_s;
  logic [7:0] wdata_r;
  logic [7:0] wdata_nxt_s;

  logic       hs_s;
  logic       sample_s;
  logic       rsp_s;

  logic       ready_r;
  logic       busy_r;
  logic [7:0] bus_addr_r;
  logic [7:0] bus_addr_nxt_s;
  logic       bus_we_r;
  logic       bus_we_nxt_s;
  logic       drive_en_r;
  logic       drive_nxt_s;
  logic       rsp_valid_r;
  logic       rsp_we_r;
  logic [7:0] rsp_rdata_r;

  // ready_r is only ever set while IDLE, so it doubles as the "accepting" qualifier
  assign hs_s = ready_r & bus_if.REQ_VALID;

  // Next-state, phase counter and request capture
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sample_s    = 1'b0;
    rsp_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        if (hs_s) begin
          state_nxt_s = bus_if.REQ_WE ? ST_WRITE : ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (cnt_r == WR_LAST) begin
          state_nxt_s = ST_TURN;
          cnt_nxt_s   = CNT_ZERO;
          rsp_s       = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_READ: begin
        if (cnt_r == RD_LAST) begin
          state_nxt_s = ST_TURN;
          cnt_nxt_s   = CNT_ZERO;
          sample_s    = 1'b1;
          rsp_s       = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_TURN: begin
        if (cnt_r == TA_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    we_nxt_s    = hs_s ? bus_if.REQ_WE    : we_r;
    addr_nxt_s  = hs_s ? bus_if.REQ_ADDR  : addr_r;
    wdata_nxt_s = hs_s ? bus_if.REQ_WDATA : wdata_r;
  end

  // Bus pin values for the coming cycle, decoded from the state being entered
  always_comb begin
    bus_addr_nxt_s = IDLE_ADDR;
    bus_we_nxt_s   = 1'b0;
    drive_nxt_s    = 1'b0;
    case (state_nxt_s)
      ST_WRITE: begin
        bus_addr_nxt_s = addr_nxt_s;
        bus_we_nxt_s   = 1'b1;
        drive_nxt_s    = 1'b1;
      end
      ST_READ: begin
        bus_addr_nxt_s = addr_nxt_s;
      end
      default: begin
        bus_addr_nxt_s = IDLE_ADDR;
        bus_we_nxt_s   = 1'b0;
        drive_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and phase counter registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Latched request and all registered outputs, including the data driver enable
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_r        <= 1'b0;
      addr_r      <= 8'h00;
      wdata_r     <= 8'h00;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      bus_addr_r  <= IDLE_ADDR;
      bus_we_r    <= 1'b0;
      drive_en_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_we_r    <= 1'b0;
      rsp_rdata_r <= 8'h00;
    end else begin
      we_r        <= we_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      ready_r     <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      bus_addr_r  <= bus_addr_nxt_s;
      bus_we_r    <= bus_we_nxt_s;
      drive_en_r  <= drive_nxt_s;
      rsp_valid_r <= rsp_s;
      rsp_we_r    <= rsp_s ? we_r : rsp_we_r;
      rsp_rdata_r <= sample_s ? BUS_DATA : rsp_rdata_r;
    end
  end

  assign BUS_DATA         = drive_en_r ? wdata_r : 8'hZZ;
  assign bus_if.REQ_READY = ready_r;
  assign bus_if.BUSY      = busy_r;
  assign bus_if.BUS_ADDR  = bus_addr_r;
  assign bus_if.BUS_WE    = bus_we_r;
  assign bus_if.RSP_VALID = rsp_valid_r;
  assign bus_if.RSP_WE    = rsp_we_r;
  assign bus_if.RSP_RDATA = rsp_rdata_r;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a two-byte responder at 8'hE0/8'hE1 with two-edge read latency,
// a table of single transfers checked through a response scoreboard, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_bus_master_port;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  typedef struct {
    logic       we;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  wire  [7:0] bus_data;

  bus_master_port_if bif ();

  bus_master_port dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus_if   (bif),
    .BUS_DATA (bus_data)
  );

  always #5 CLK = ~CLK;

  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   we_cycles = 0;
  int   gap = 0;
  int   min_gap = 99;
  int   last_hs = 0;
  int   hs_gap = 0;
  bit   seen_model = 1'b0;
  bit   rsp_prev = 1'b0;
  logic [7:0] cur_wdata = 8'h00;
  logic [7:0] cur_addr = 8'h00;
  logic [7:0] last_rd = 8'h00;
  exp_t sb_q[$];

  // Responder model: registered two-stage address decode, drives one cycle past address removal
  logic       model_load = 1'b0;
  logic [7:0] model_mem [2];
  logic       hit1_r = 1'b0;
  logic       drv_r = 1'b0;
  logic       sel1_r = 1'b0;
  logic       sel_r = 1'b0;
  wire        map_s = (bif.BUS_ADDR[7:1] == 7'h70);
  wire        rd_hit_s = map_s && !bif.BUS_WE;

  always @(posedge CLK) begin
    hit1_r <= rd_hit_s;
    drv_r  <= hit1_r && rd_hit_s;
    sel1_r <= bif.BUS_ADDR[0];
    sel_r  <= sel1_r;
    if (model_load) begin
      model_mem[0] <= 8'hC3;
      model_mem[1] <= 8'h3C;
    end else if (bif.BUS_WE && map_s) begin
      model_mem[bif.BUS_ADDR[0]] <= bus_data;
    end
  end

  assign bus_data = drv_r ? model_mem[sel_r] : 8'hzz;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus ownership, write data, response scoreboard, pulse width
  always @(negedge CLK) begin
    exp_t e;
    if (drv_r) begin
      chk("no_contention", {31'd0, bif.BUS_WE}, 32'd0);
      seen_model = 1'b1;
      gap = 0;
    end else if (bif.BUS_WE) begin
      if (seen_model) begin
        if (gap < min_gap) min_gap = gap;
        seen_model = 1'b0;
      end
      chk("wr_bus_data", {24'd0, bus_data}, {24'd0, cur_wdata});
      chk("wr_bus_addr", {24'd0, bif.BUS_ADDR}, {24'd0, cur_addr});
      we_cycles++;
    end else begin
      gap++;
    end
    if (rsp_prev) chk("rsp_pulse", {31'd0, bif.RSP_VALID}, 32'd0);
    rsp_prev = bif.RSP_VALID;
    if (bif.RSP_VALID) begin
      rsp_cnt++;
      chk("rsp_busy", {31'd0, bif.BUSY}, 32'd1);
      chk("rsp_ready", {31'd0, bif.REQ_READY}, 32'd0);
      if (sb_q.size() == 0) begin
        vec++;
        miss++;
        $display("FAIL unexpected_rsp: got RSP_VALID with no request pending (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_we", {31'd0, bif.RSP_WE}, {31'd0, e.we});
        if (e.we) begin
          chk("wr_latency", cyc - e.cyc - 1, 32'd1);
          chk("wr_we_cycles", we_cycles, 32'd1);
          chk("rdata_hold", {24'd0, bif.RSP_RDATA}, {24'd0, last_rd});
        end else begin
          chk("rd_latency", cyc - e.cyc - 1, 32'd3);
          chk("rd_data", {24'd0, bif.RSP_RDATA}, {24'd0, e.rdata});
          last_rd = e.rdata;
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit hold);
    bit   ok;
    exp_t e;
    bif.REQ_VALID = 1'b1;
    bif.REQ_WE    = v.we;
    bif.REQ_ADDR  = v.addr;
    bif.REQ_WDATA = v.wdata;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (bif.REQ_READY) begin
        e.we      = v.we;
        e.rdata   = v.rdata;
        e.cyc     = cyc;
        sb_q.push_back(e);
        cur_wdata = v.wdata;
        cur_addr  = v.addr;
        we_cycles = 0;
        hs_gap    = cyc - last_hs;
        last_hs   = cyc;
        ok        = 1'b1;
      end
    end
    if (!ok) begin
      vec++;
      miss++;
      $display("FAIL hs_timeout: got REQ_READY=0 for 40 cycles expected acceptance (addr %0h)", v.addr);
    end
    @(posedge CLK);
    #1;
    if (ok) begin
      chk("ready_after_hs", {31'd0, bif.REQ_READY}, 32'd0);
      chk("busy_after_hs", {31'd0, bif.BUSY}, 32'd1);
    end
    if (!hold) begin
      bif.REQ_VALID = 1'b0;
      bif.REQ_ADDR  = 8'($urandom);
      bif.REQ_WDATA = 8'($urandom);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge CLK);
    if (sb_q.size() != 0) begin
      vec++;
      miss++;
      $display("FAIL rsp_timeout: got %0d responses outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  vec_t tbl [12];
  int   rsp_before;

  initial begin
    tbl[0]  = '{1'b0, 8'hE0, 8'h00, 8'hC3};
    tbl[1]  = '{1'b1, 8'hE0, 8'h5A, 8'h00};
    tbl[2]  = '{1'b0, 8'hE0, 8'h00, 8'h5A};
    tbl[3]  = '{1'b1, 8'hE1, 8'hA5, 8'h00};
    tbl[4]  = '{1'b0, 8'hE1, 8'h00, 8'hA5};
    tbl[5]  = '{1'b0, 8'hE0, 8'h00, 8'h5A};
    tbl[6]  = '{1'b1, 8'h10, 8'h77, 8'h00};
    tbl[7]  = '{1'b0, 8'hE1, 8'h00, 8'hA5};
    tbl[8]  = '{1'b1, 8'hE0, 8'h00, 8'h00};
    tbl[9]  = '{1'b0, 8'hE0, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 8'hE0, 8'hFF, 8'h00};
    tbl[11] = '{1'b0, 8'hE0, 8'h00, 8'hFF};

    bif.REQ_VALID = 1'b0;
    bif.REQ_WE    = 1'b0;
    bif.REQ_ADDR  = 8'h00;
    bif.REQ_WDATA = 8'h00;
    RESET         = 1'b0;
    model_load    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    model_load = 1'b0;
    @(negedge CLK);
    chk("rst_ready", {31'd0, bif.REQ_READY}, 32'd0);
    chk("rst_busy", {31'd0, bif.BUSY}, 32'd0);
    chk("rst_bus_addr", {24'd0, bif.BUS_ADDR}, 32'hFF);
    chk("rst_bus_we", {31'd0, bif.BUS_WE}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bif.RSP_VALID}, 32'd0);
    chk("rst_rsp_we", {31'd0, bif.RSP_WE}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, bif.RSP_RDATA}, 32'd0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    chk("ready_after_rst", {31'd0, bif.REQ_READY}, 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(tbl[i], 1'b0);
      drain();
    end

    // Back-to-back write then read with REQ_VALID held: 1 + 1 + 1 cycles apart
    send('{1'b1, 8'hE0, 8'h11, 8'h00}, 1'b1);
    send('{1'b0, 8'hE0, 8'h00, 8'h11}, 1'b0);
    chk("b2b_wr_rd_period", hs_gap, 32'd3);
    drain();

    // Read then write held: 1 + 3 + 1 cycles apart, one released cycle after responder drive-off
    min_gap    = 99;
    seen_model = 1'b0;
    send('{1'b0, 8'hE1, 8'h00, 8'hA5}, 1'b1);
    send('{1'b1, 8'h10, 8'h22, 8'h00}, 1'b0);
    chk("b2b_rd_wr_period", hs_gap, 32'd5);
    drain();
    chk("turnaround_gap", min_gap, 32'd1);

    // Request pulsed while busy must be ignored
    rsp_before = rsp_cnt;
    send('{1'b0, 8'hE0, 8'h00, 8'h11}, 1'b0);
    bif.REQ_VALID = 1'b1;
    bif.REQ_WE    = 1'b1;
    bif.REQ_ADDR  = 8'hE0;
    bif.REQ_WDATA = 8'hEE;
    @(negedge CLK);
    chk("ready_while_busy", {31'd0, bif.REQ_READY}, 32'd0);
    @(posedge CLK);
    #1;
    bif.REQ_VALID = 1'b0;
    drain();
    repeat (6) @(posedge CLK);
    #1;
    chk("ignored_rsp_count", rsp_cnt - rsp_before, 32'd1);
    send('{1'b0, 8'hE0, 8'h00, 8'h11}, 1'b0);
    drain();

    // Reset in the middle of a read: bus idles at once, no response for the aborted read
    send('{1'b0, 8'hE0, 8'h00, 8'h11}, 1'b0);
    @(posedge CLK);
    #2;
    chk("pre_abort_addr", {24'd0, bif.BUS_ADDR}, 32'hE0);
    RESET = 1'b0;
    #1;
    chk("abort_bus_addr", {24'd0, bif.BUS_ADDR}, 32'hFF);
    chk("abort_bus_we", {31'd0, bif.BUS_WE}, 32'd0);
    chk("abort_busy", {31'd0, bif.BUSY}, 32'd0);
    chk("abort_ready", {31'd0, bif.REQ_READY}, 32'd0);
    chk("abort_rsp_valid", {31'd0, bif.RSP_VALID}, 32'd0);
    chk("abort_rdata", {24'd0, bif.RSP_RDATA}, 32'd0);
    sb_q.delete();
    last_rd    = 8'h00;
    rsp_before = rsp_cnt;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("no_rsp_after_abort", rsp_cnt - rsp_before, 32'd0);
    send('{1'b1, 8'hE1, 8'h6B, 8'h00}, 1'b0);
    drain();
    send('{1'b0, 8'hE1, 8'h00, 8'h6B}, 1'b0);
    drain();
    send('{1'b0, 8'hE0, 8'h00, 8'h11}, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
